// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I type definitions used across the lab codebase.
// Provides rv32i_word, the 32-bit datapath word used for addresses and data.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between an initiator and a memory responder.
// Signals:
//   mem_read, mem_write   request strobes from the initiator
//   mem_byte_enable[3:0]  write lane enables, bit i covers mem_wdata[8i+7:8i]
//   mem_address           byte address
//   mem_wdata             write data
//   mem_resp              one-cycle completion pulse from the responder
//   mem_rdata             read data, meaningful only while mem_resp is high
// Modports: master (initiator side), slave (responder side).
interface mem_responder_if;

  logic                  mem_read;
  logic                  mem_write;
  logic [3:0]            mem_byte_enable;
  rv32i_types::rv32i_word mem_address;
  rv32i_types::rv32i_word mem_wdata;
  logic                  mem_resp;
  rv32i_types::rv32i_word mem_rdata;

  modport master (
    output mem_read,
    output mem_write,
    output mem_byte_enable,
    output mem_address,
    output mem_wdata,
    input  mem_resp,
    input  mem_rdata
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_byte_enable,
    input  mem_address,
    input  mem_wdata,
    output mem_resp,
    output mem_rdata
  );

endinterface

// File: rtl/mem_responder_array.sv
// mem_responder_array: DEPTH_WORDS x 32 single-port storage with per-byte write
// enables, synchronous write and combinational read.
// Ports:
//   clk    clock, writes land on its rising edge
//   we     write strobe
//   be     byte lane enables for the write
//   index  word index shared by read and write
//   wdata  write data
//   rdata  combinational read of the word at index
// Contents start at zero and are never cleared afterwards (no reset input).
module mem_responder_array
  import rv32i_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] index,
  input  rv32i_word        wdata,
  output rv32i_word        rdata
);

  rv32i_word storage [DEPTH_WORDS] = '{default: '0};

  // Byte-lane write: only lanes whose enable bit is set are updated, so a
  // write with be=0000 leaves the word untouched.
  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (we && be[lane]) begin
        storage[index][8*lane +: 8] <= wdata[8*lane +: 8];
      end
    end
  end

  assign rdata = storage[index];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory target that accepts one read or write request at a time
// and completes it with a one-cycle mem_resp pulse LATENCY cycles after acceptance.
// Parameters:
//   DEPTH_WORDS  storage size in 32-bit words (power of two, >= 2)
//   LATENCY      cycles from acceptance edge to mem_resp (>= 1)
// Ports:
//   clk   clock
//   rst   synchronous active-high reset (storage contents survive it)
//   bus   mem_responder_if slave side
//   err   sticky protocol-error flag
// Optional feature: define MEM_RESPONDER_CHECK_EN to build the protocol checker
// that sets err on a read+write request, a misaligned address, or an address
// beyond the storage. Without it err is tied low.
module mem_responder
  import rv32i_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus,
  output logic            err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] lat_index;
  logic             lat_read_only;

  logic             accept;
  logic             live_read_only;
  logic             array_we;
  logic [IDX_W-1:0] live_index;
  logic [IDX_W-1:0] arr_index;
  rv32i_word        arr_rdata;
  logic             unused_addr_bits;

  // A request is only taken in IDLE; in WAIT and RESP the bus is ignored and
  // the latched index drives the array. Writes commit on the acceptance edge
  // itself, so byte enables and write data never need to be held. A request
  // with both strobes set is a write and returns no read data.
  assign accept         = (state == IDLE) && (bus.mem_read || bus.mem_write);
  assign live_read_only = bus.mem_read && !bus.mem_write;
  assign live_index     = bus.mem_address[IDX_W+1:2];
  assign arr_index      = (state == IDLE) ? live_index : lat_index;
  assign array_we       = accept && bus.mem_write;

  assign unused_addr_bits = &{1'b0, bus.mem_address[1:0], bus.mem_address[31:IDX_W+2]};

  mem_responder_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (array_we),
    .be    (bus.mem_byte_enable),
    .index (arr_index),
    .wdata (bus.mem_wdata),
    .rdata (arr_rdata)
  );

  // Request FSM with registered outputs. The counter is loaded with LATENCY-1
  // at acceptance and RESP is entered when it reaches 1, so mem_resp is seen
  // high at the LATENCY-th rising edge counted from the acceptance edge.
  // mem_resp and mem_rdata are set on the same edge that enters RESP and
  // cleared on the edge that leaves it, which gives an exact one-cycle pulse
  // and zero read data at all other times.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      lat_index     <= '0;
      lat_read_only <= 1'b0;
      bus.mem_resp  <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.mem_resp  <= 1'b0;
          bus.mem_rdata <= '0;
          if (accept) begin
            lat_index     <= live_index;
            lat_read_only <= live_read_only;
            count         <= CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              state         <= RESP;
              bus.mem_resp  <= 1'b1;
              bus.mem_rdata <= live_read_only ? arr_rdata : '0;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            state         <= RESP;
            bus.mem_resp  <= 1'b1;
            bus.mem_rdata <= lat_read_only ? arr_rdata : '0;
          end
        end
        RESP: begin
          state         <= IDLE;
          bus.mem_resp  <= 1'b0;
          bus.mem_rdata <= '0;
        end
        default: begin
          state         <= IDLE;
          bus.mem_resp  <= 1'b0;
          bus.mem_rdata <= '0;
        end
      endcase
    end
  end

`ifdef MEM_RESPONDER_CHECK_EN
  logic violation;

  assign violation = (bus.mem_read && bus.mem_write)
                   || (bus.mem_address[1:0] != 2'b00)
                   || (|(bus.mem_address >> (IDX_W + 2)));

  // Sticky protocol checker: any bad request seen at acceptance latches err
  // until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && violation) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder.
// Two instances: u_dut (LATENCY=3) carries most scenarios, u_dut_lat1
// (LATENCY=1) carries the back-to-back pattern. Expected read data is pushed
// to a scoreboard queue when a request is driven and popped on mem_resp.
// Honours MEM_RESPONDER_CHECK_EN for the expected err value.
module tb_mem_responder;
  import rv32i_types::*;

  localparam int DEPTH = 1024;
`ifdef MEM_RESPONDER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic err0;
  logic err1;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0),
    .err (err0)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_lat1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1),
    .err (err1)
  );

  always #5 clk = ~clk;

  rv32i_word model0 [DEPTH];
  rv32i_word model1 [DEPTH];
  rv32i_word exp_q [$];
  bit        err_exp0;
  int        checks   = 0;
  int        failures = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic int wordIdx(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  function automatic rv32i_word mergeBytes(input rv32i_word old_w, input rv32i_word new_w, input logic [3:0] be);
    rv32i_word r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  function automatic bit isViolation(input logic rd, input logic wr, input logic [31:0] addr);
    return (rd && wr) || (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
  endfunction

  // Drive one request into u_dut, update the model and scoreboard, scramble
  // the bus while the request is in flight, then wait for and check mem_resp.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
    int        waited;
    bit        seen;
    rv32i_word exp;
    bus0.mem_read        = rd;
    bus0.mem_write       = wr;
    bus0.mem_byte_enable = be;
    bus0.mem_address     = addr;
    bus0.mem_wdata       = wdata;
    if (wr) model0[wordIdx(addr)] = mergeBytes(model0[wordIdx(addr)], wdata, be);
    exp_q.push_back((rd && !wr) ? model0[wordIdx(addr)] : 32'h0);
    if (CHECK_EN && isViolation(rd, wr, addr)) err_exp0 = 1'b1;
    @(posedge clk);
    #1;
    bus0.mem_read        = 1'b1;
    bus0.mem_write       = 1'b1;
    bus0.mem_byte_enable = 4'hF;
    bus0.mem_address     = $urandom;
    bus0.mem_wdata       = $urandom;
    waited = 1;
    seen   = 1'b0;
    while (!seen && waited <= 16) begin
      if (bus0.mem_resp === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        waited++;
      end
    end
    bus0.mem_read        = 1'b0;
    bus0.mem_write       = 1'b0;
    bus0.mem_byte_enable = 4'h0;
    bus0.mem_address     = '0;
    bus0.mem_wdata       = '0;
    if (!seen) begin
      checkOutput({tag, " resp timeout"}, 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      @(posedge clk);
      #1;
    end else begin
      checkOutput({tag, " latency"}, 32'(waited), 32'd3);
      exp = exp_q.pop_front();
      checkOutput({tag, " rdata"}, bus0.mem_rdata, exp);
      @(posedge clk);
      #1;
      checkOutput({tag, " resp one cycle"}, 32'(bus0.mem_resp), 32'd0);
      checkOutput({tag, " rdata after resp"}, bus0.mem_rdata, 32'h0);
    end
    checkOutput({tag, " err"}, 32'(err0), 32'(err_exp0));
  endtask

  task automatic pulseReset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    err_exp0 = 1'b0;
    checkOutput({tag, " resp"}, 32'(bus0.mem_resp), 32'd0);
    checkOutput({tag, " rdata"}, bus0.mem_rdata, 32'h0);
    checkOutput({tag, " err"}, 32'(err0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic       rd_t [3];
    logic       wr_t [3];
    logic [31:0] wd_t [3];
    rv32i_word  exp;

    foreach (model0[i]) model0[i] = '0;
    foreach (model1[i]) model1[i] = '0;
    err_exp0 = 1'b0;
    bus0.mem_read = 1'b0; bus0.mem_write = 1'b0; bus0.mem_byte_enable = 4'h0;
    bus0.mem_address = '0; bus0.mem_wdata = '0;
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0; bus1.mem_byte_enable = 4'h0;
    bus1.mem_address = '0; bus1.mem_wdata = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset resp", 32'(bus0.mem_resp), 32'd0);
    checkOutput("reset rdata", bus0.mem_rdata, 32'h0);
    checkOutput("reset err", 32'(err0), 32'd0);
    rst = 1'b0;

    $display("[TB] full-word write then read");
    applyStimulus("w100", 1'b0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
    applyStimulus("r100", 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);

    $display("[TB] partial byte-lane write");
    applyStimulus("w200 preset", 1'b0, 1'b1, 4'hF, 32'h200, 32'h11223344);
    applyStimulus("w200 be0101", 1'b0, 1'b1, 4'b0101, 32'h200, 32'hAABBCCDD);
    applyStimulus("r200", 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    applyStimulus("w200 be0000", 1'b0, 1'b1, 4'b0000, 32'h200, 32'hFFFFFFFF);
    applyStimulus("r200 after noop", 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);

    $display("[TB] reset during WAIT of a read");
    bus0.mem_read    = 1'b1;
    bus0.mem_address = 32'h100;
    @(posedge clk);
    #1;
    bus0.mem_read    = 1'b0;
    bus0.mem_address = '0;
    pulseReset("abort");
    @(posedge clk);
    #1;
    checkOutput("abort no resp 1", 32'(bus0.mem_resp), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("abort no resp 2", 32'(bus0.mem_resp), 32'd0);
    applyStimulus("r100 after abort", 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);

    $display("[TB] out-of-range address wraps");
    applyStimulus("w1004", 1'b0, 1'b1, 4'hF, 32'h1004, 32'h5A5A5A5A);
    applyStimulus("r4", 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
    pulseReset("rst keeps storage");
    applyStimulus("r4 after rst", 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);

    $display("[TB] simultaneous read and write");
    applyStimulus("rw8", 1'b1, 1'b1, 4'hF, 32'h8, 32'h1);
    applyStimulus("r8", 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    applyStimulus("r102 misaligned", 1'b1, 1'b0, 4'hF, 32'h102, 32'h0);

    $display("[TB] LATENCY=1 back-to-back read, write, read");
    rd_t[0] = 1'b1; wr_t[0] = 1'b0; wd_t[0] = 32'h0;
    rd_t[1] = 1'b0; wr_t[1] = 1'b1; wd_t[1] = 32'hCAFEF00D;
    rd_t[2] = 1'b1; wr_t[2] = 1'b0; wd_t[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      bus1.mem_read        = rd_t[i];
      bus1.mem_write       = wr_t[i];
      bus1.mem_byte_enable = 4'hF;
      bus1.mem_address     = 32'h40;
      bus1.mem_wdata       = wd_t[i];
      if (wr_t[i]) model1[wordIdx(32'h40)] = mergeBytes(model1[wordIdx(32'h40)], wd_t[i], 4'hF);
      exp_q.push_back((rd_t[i] && !wr_t[i]) ? model1[wordIdx(32'h40)] : 32'h0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("b2b[%0d] resp", i), 32'(bus1.mem_resp), 32'd1);
      exp = exp_q.pop_front();
      checkOutput($sformatf("b2b[%0d] rdata", i), bus1.mem_rdata, exp);
      if (i < 2) begin
        bus1.mem_read  = rd_t[i+1];
        bus1.mem_write = wr_t[i+1];
        bus1.mem_wdata = wd_t[i+1];
      end else begin
        bus1.mem_read  = 1'b0;
        bus1.mem_write = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("b2b[%0d] gap", i), 32'(bus1.mem_resp), 32'd0);
    end
    checkOutput("b2b err", 32'(err1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the storage size in 32-bit words; it must be a power of two and at least 2.
REQ-002 Parameter LATENCY, default 3, SHALL set the number of cycles from request acceptance to mem_resp; it must be at least 1.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 mem_read  input  1  SHALL carry the initiator's read request.
REQ-006 mem_write  input  1  SHALL carry the initiator's write request.
REQ-007 mem_byte_enable  input  4  SHALL carry the write lane enables; bit i enables mem_wdata[8i+7:8i].
REQ-008 mem_address  input  32 (rv32i_word)  SHALL carry the byte address.
REQ-009 mem_wdata  input  32 (rv32i_word)  SHALL carry the write data.
REQ-010 mem_resp  output  1  SHALL be a one-cycle completion pulse.
REQ-011 mem_rdata  output  32 (rv32i_word)  SHALL carry the read data, valid only while mem_resp=1.
REQ-012 err  output  1  SHALL be a sticky protocol-error flag (see Configuration).

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-014 IDLE, with mem_read|mem_write=1 at a rising edge: the request is accepted; address, byte enable, wdata and operation are latched; the latency counter loads LATENCY-1.
- If LATENCY=1 the next state is RESP; otherwise it is WAIT.
REQ-015 WAIT SHALL decrement the counter each cycle and go to RESP when the counter reaches 1.
REQ-016 RESP SHALL drive mem_resp=1 for exactly one cycle, then return to IDLE unconditionally.
- The request visible in the cycle after RESP is a new request.
REQ-017 mem_resp SHALL rise exactly LATENCY cycles after the acceptance edge.
REQ-018 Inputs changing during WAIT or RESP SHALL be ignored; only latched values are used.
REQ-019 Word index SHALL be the latched address bits [log2(DEPTH_WORDS)+1:2].
- Bits [1:0] are ignored.
- Higher address bits are discarded, so out-of-range addresses wrap modulo DEPTH_WORDS.
REQ-020 A write SHALL commit at the acceptance edge, updating only the enabled byte lanes.
- mem_byte_enable=0000 is a legal no-op write that still returns mem_resp.
REQ-021 A read SHALL drive mem_rdata during RESP with the word at the latched index, including any earlier committed write.
- mem_rdata SHALL be 0 outside RESP.
REQ-022 If mem_read and mem_write are both 1 at acceptance, the request SHALL be treated as a write, and mem_rdata stays 0 during RESP.
REQ-023 Back-to-back requests SHALL be served with no extra idle cycle beyond RESP.

Reset
REQ-024 rst=1 at any edge SHALL force the FSM to IDLE, clear the counter and latched request, and drive mem_resp=0, mem_rdata=0, err=0 from the next cycle.
REQ-025 rst SHALL abort an in-flight request with no mem_resp issued.
- A write already committed at acceptance is retained.
REQ-026 Storage contents SHALL NOT be cleared by rst.
- The array is zero-initialised at time 0 only.

Configuration
REQ-027 Macro MEM_RESPONDER_CHECK_EN defined: err SHALL set, and stay set until rst, when any of these occurs at acceptance:
- mem_read and mem_write are both 1;
- mem_address[1:0] != 0;
- mem_address >= 4*DEPTH_WORDS.
REQ-028 Macro MEM_RESPONDER_CHECK_EN undefined: err SHALL be tied to 0 and no check logic is built.
- All other behaviour is unchanged.

Structure
REQ-029 rv32i_word SHALL come from the shared rv32i_types package.
- The FSM state enum stays local to the module; no new package content.
REQ-030 Storage SHALL be one sub-module, mem_responder_array: a byte-enabled, single-port, DEPTH_WORDS x 32 synchronous-write, combinational-read array.

Verification
REQ-031 LATENCY=3: write 0xDEADBEEF, be=1111, to 0x100; then read 0x100 -> each mem_resp arrives 3 cycles after acceptance, and the read returns 0xDEADBEEF.
REQ-032 Word at 0x200 preset to 0x11223344; write be=0101, wdata=0xAABBCCDD; read 0x200 -> returns 0x11BB33DD.
REQ-033 LATENCY=1: back-to-back read, write, read with no gap -> mem_resp high on alternate cycles and never for two consecutive cycles.
REQ-034 DEPTH_WORDS=1024: write 0x5A5A5A5A to 0x1004; read 0x4 -> returns 0x5A5A5A5A; with MEM_RESPONDER_CHECK_EN, err=1 after the write.
REQ-035 rst asserted in WAIT of a read -> no mem_resp pulse; FSM in IDLE next cycle; a fresh read completes normally with correct latency.
REQ-036 mem_read=mem_write=1, address 0x8, wdata 0x1, be=1111 -> write performed, mem_rdata=0 in RESP; err=1 only when MEM_RESPONDER_CHECK_EN is defined.
